uart_dbg_host: RTL and testbench
================================

Name: uart_dbg_host

Overview:
- Host-side initiator for the single-byte UART debug protocol used by the FPGA core's debug bridge.
- Accepts a command code over a valid/ready handshake and serialises it as an 8N1 frame on tx.
- For read commands, it receives the 4-byte little-endian reply on rx and presents it as one 32-bit word.
- Used in loopback/self-test builds and in the board-to-board debug harness.

Parameters:
- CLKS_PER_BIT, 5002: clk cycles per UART bit. Minimum 4.
- TIMEOUT_BITS, 64: bit periods to wait for a reply start bit. Used only with UART_DBG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_code  in  3  1=RST_CPU, 2=STEP_CPU, 3=READ_ADDR, 4=READ_RDATA, 5=READ_WDATA
- rsp_valid  out  1  one-cycle pulse when a reply word or an error is delivered
- rsp_data  out  32  assembled reply; byte 0 is received first and lands in bits 7:0
- rsp_err  out  1  qualifies rsp_valid; 1 = framing error or timeout
- busy  out  1  high when not in IDLE
- tx  out  1  serial out, idles high
- rx  in  1  serial in, asynchronous

Behaviour:
- Reset (synchronous, active-high):
  - tx=1, cmd_ready=1 (state IDLE), rsp_valid=0, rsp_err=0, rsp_data=0, busy=0.
  - Bit counter, byte counter and baud counter all cleared.
  - rst mid-frame drives tx=1 on the next edge and abandons any transfer; no rsp_valid is issued.
- rx input: passes through a 2-flop synchroniser before any use.
- Handshake: a transfer occurs on the clk edge where cmd_valid && cmd_ready. cmd_code is latched at that edge. Transmitted byte = {5'b0, cmd_code}.
- Every bit on tx or rx lasts exactly CLKS_PER_BIT clk cycles. The baud counter restarts on each state change.
- State machine:
  - IDLE: tx=1. On handshake -> TX_START.
  - TX_START: tx=0 for one bit -> TX_DATA.
  - TX_DATA: 8 bits, LSB first -> TX_STOP.
  - TX_STOP: tx=1 for one bit. Then codes 3/4/5 -> RX_WAIT; all other codes (1, 2, and 0/6/7, which the target ignores) -> IDLE.
  - RX_WAIT: wait for synchronised rx=0 -> RX_START.
  - RX_START: sample at CLKS_PER_BIT/2. If rx=1, treat as a glitch and return to RX_WAIT. Otherwise -> RX_DATA, with sampling at mid-bit from then on.
  - RX_DATA: 8 mid-bit samples shifted in LSB first, placed into byte lane byte_cnt -> RX_STOP.
  - RX_STOP: mid-bit sample. If 1 and byte_cnt<3: byte_cnt++ -> RX_WAIT. If 1 and byte_cnt==3 -> DONE. If 0 -> ERR.
  - DONE: rsp_valid=1, rsp_err=0 for one cycle -> IDLE.
  - ERR: wait until synchronised rx=1, then pulse rsp_valid=1 with rsp_err=1 for one cycle -> IDLE. rsp_data holds the partial word.
- Back-to-back commands: cmd_ready rises the cycle after the TX_STOP bit (write-only commands) or after the DONE/ERR pulse. Minimum gap between command frames = one stop bit.
- rsp_data is stable from the rsp_valid pulse until the next accepted read command. It is cleared to 0 when a read command is accepted.
- cmd_valid while busy: ignored and not queued.
- Ordering: tx and rx are never active simultaneously, because the protocol is strictly request/response.

Optional Feature:
- Macro: UART_DBG_TIMEOUT_EN.
- Defined:
  - A counter runs in RX_WAIT. After TIMEOUT_BITS*CLKS_PER_BIT cycles with no start bit -> pulse rsp_valid with rsp_err=1 -> IDLE.
  - The counter resets on each entry to RX_WAIT, i.e. the timeout applies per byte.
- Undefined: RX_WAIT waits indefinitely. Only rst recovers a dead target.

Test Plan:
- Reset, then cmd_code=2 with CLKS_PER_BIT=8 -> tx shows 0 then 0,1,0,0,0,0,0,0 then 1, each 8 cycles. cmd_ready returns after 80 cycles. No rsp_valid.
- cmd_code=3; bench target replies with bytes 0x78,0x56,0x34,0x12 -> single rsp_valid pulse, rsp_data=0x12345678, rsp_err=0.
- cmd_code=4; target sends a 1-cycle rx low glitch, then a valid reply 0xDEADBEEF -> glitch ignored, rsp_data=0xDEADBEEF.
- cmd_code=5; stop bit of byte 2 held 0, then rx returns high -> rsp_valid with rsp_err=1. rsp_data[15:0] holds bytes 0-1.
- rst asserted during the 4th data bit of TX_DATA -> tx=1 next cycle, cmd_ready=1, no rsp_valid. A following cmd_code=1 frame is correct.
- With UART_DBG_TIMEOUT_EN and TIMEOUT_BITS=4, cmd_code=3 with no reply -> rsp_err pulse exactly 32 cycles after entering RX_WAIT (CLKS_PER_BIT=8). Without the macro, busy stays high indefinitely.

Source files
------------

// File: rtl/uart_dbg_host.sv
// Host-side initiator for the single-byte UART debug protocol: sends a command
// code as an 8N1 frame and, for read commands, assembles the 4-byte reply.
// Optional build macro UART_DBG_TIMEOUT_EN bounds the wait for each reply byte.
module uart_dbg_host #(
  parameter int CLKS_PER_BIT = 5002,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_code,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        tx,
  input  logic        rx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_bad_param
    $error("uart_dbg_host: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP,
    RX_WAIT, RX_START, RX_DATA, RX_STOP,
    DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        tx_byte;
  logic [7:0]        rx_shift;
  logic [31:0]       rsp_data_q;
  logic              rx_p0, rx_p1;
  logic              bit_done;

  function automatic logic is_read(input logic [2:0] code);
    return (code == 3'd3) || (code == 3'd4) || (code == 3'd5);
  endfunction

`ifdef UART_DBG_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_W'(TO_CYC));

  always_ff @(posedge clk) begin
    if (rst || state_q != RX_WAIT) to_cnt <= '0;
    else                           to_cnt <= to_cnt + 1'b1;
  end
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  assign bit_done = (baud_cnt == BIT_LAST);
  assign rsp_data = rsp_data_q;

  // rx synchroniser stage p0 -> p1; only rx_p1 is used by the FSM
  always_ff @(posedge clk) begin
    rx_p0 <= rx;
    rx_p1 <= rx_p0;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    tx        = 1'b1;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = TX_START;
      end
      TX_START: begin
        tx = 1'b0;
        if (bit_done) state_d = TX_DATA;
      end
      TX_DATA: begin
        tx = tx_byte[bit_cnt];
        if (bit_done && bit_cnt == 3'd7) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_done) state_d = is_read(tx_byte[2:0]) ? RX_WAIT : IDLE;
      end
      RX_WAIT: begin
        if (!rx_p1) begin
          state_d = RX_START;
        end else if (to_hit) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end
      end
      RX_START: begin
        // A start bit that is gone by mid-bit was line noise
        if (baud_cnt == HALF_LAST) state_d = rx_p1 ? RX_WAIT : RX_DATA;
      end
      RX_DATA: begin
        if (bit_done && bit_cnt == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: begin
        if (bit_done) begin
          if (!rx_p1)               state_d = ERR;
          else if (byte_cnt == 2'd3) state_d = DONE;
          else                       state_d = RX_WAIT;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        if (rx_p1) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q || bit_done) baud_cnt <= '0;
      else                                baud_cnt <= baud_cnt + 1'b1;

      if (state_d != state_q)
        bit_cnt <= '0;
      else if (bit_done && (state_q == TX_DATA || state_q == RX_DATA))
        bit_cnt <= bit_cnt + 1'b1;

      if (state_q == IDLE)
        byte_cnt <= '0;
      else if (state_q == RX_STOP && state_d == RX_WAIT)
        byte_cnt <= byte_cnt + 1'b1;

      if (state_q == IDLE && cmd_valid && is_read(cmd_code))
        rsp_data_q <= '0;
      else if (state_q == RX_DATA && bit_done)
        rsp_data_q[{byte_cnt, 3'b000} +: 8] <= {rx_p1, rx_shift[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && cmd_valid) tx_byte <= {5'b0, cmd_code};
    if (state_q == RX_DATA && bit_done) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

endmodule

// File: tb/tb_uart_dbg_host.sv
// Directed bench for uart_dbg_host at CLKS_PER_BIT=8: write frames, read replies,
// rx glitch, framing error, mid-frame reset and reply timeout / endless wait.
module tb_uart_dbg_host;
  localparam int CPB = 8;
  localparam int TOB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_code = 3'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        tx;
  logic        rx = 1'b1;

  int          total = 0;
  int          bad = 0;
  int          vld_cnt = 0;
  int          v0;
  logic [31:0] cap_data = '0;
  logic        cap_err = 1'b0;

  uart_dbg_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  // Records each response pulse using the values settled before the edge
  always @(posedge clk) begin
    if (rsp_valid === 1'b1) begin
      vld_cnt  = vld_cnt + 1;
      cap_data = rsp_data;
      cap_err  = rsp_err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] code);
    cmd_code  = code;
    cmd_valid = 1'b1;
    chk("ready_at_issue", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Checks every cycle of the 10-bit frame, then the state one cycle after the stop bit
  task automatic check_frame(input logic [2:0] code, input logic read_cmd, input string tag);
    logic [9:0] frame;
    frame = {1'b1, 5'b0, code, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      chk({tag, "_tx"}, {31'b0, tx}, {31'b0, frame[k / CPB]});
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'b0, cmd_ready}, {31'b0, ~read_cmd});
    chk({tag, "_busy_after"}, {31'b0, busy}, {31'b0, read_cmd});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  initial begin
    // reset state
    tick(4);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    tick(2);

    // write command 2
    issue(3'd2);
    check_frame(3'd2, 1'b0, "step");
    chk("step_no_rsp", vld_cnt, 32'd0);

    // code 7 is write-only; a request while busy must not be queued
    tick(1);
    issue(3'd7);
    tick(20);
    cmd_code  = 3'd1;
    cmd_valid = 1'b1;
    tick(3);
    cmd_valid = 1'b0;
    tick(57);
    chk("c7_busy_79", {31'b0, busy}, 32'd1);
    tick(1);
    chk("c7_ready_80", {31'b0, cmd_ready}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      chk("no_queued_tx", {30'b0, tx, cmd_ready}, 32'd3);
    end

    // read command 3 with reply 0x12345678
    issue(3'd3);
    check_frame(3'd3, 1'b1, "rd3");
    tick(3);
    v0 = vld_cnt;
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("rd3_no_early_rsp", vld_cnt, v0);
    send_byte(8'h12, 1'b1);
    tick(2);
    chk("rd3_pulses", vld_cnt, v0 + 1);
    chk("rd3_data", cap_data, 32'h12345678);
    chk("rd3_err", {31'b0, cap_err}, 32'd0);
    chk("rd3_ready", {31'b0, cmd_ready}, 32'd1);
    tick(5);
    chk("rd3_data_held", rsp_data, 32'h12345678);

    // read command 4 with a one-cycle rx glitch before the reply
    issue(3'd4);
    check_frame(3'd4, 1'b1, "rd4");
    chk("rd4_cleared", rsp_data, 32'd0);
    v0 = vld_cnt;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    chk("rd4_glitch_busy", {31'b0, busy}, 32'd1);
    chk("rd4_glitch_no_rsp", vld_cnt, v0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    tick(2);
    chk("rd4_pulses", vld_cnt, v0 + 1);
    chk("rd4_data", cap_data, 32'hDEADBEEF);
    chk("rd4_err", {31'b0, cap_err}, 32'd0);

    // read command 5 with a bad stop bit on byte 2
    issue(3'd5);
    check_frame(3'd5, 1'b1, "rd5");
    chk("rd5_cleared", rsp_data, 32'd0);
    v0 = vld_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h99, 1'b0);
    tick(8);
    chk("rd5_wait_line_high", vld_cnt, v0);
    chk("rd5_busy_in_err", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    tick(5);
    chk("rd5_pulses", vld_cnt, v0 + 1);
    chk("rd5_err", {31'b0, cap_err}, 32'd1);
    chk("rd5_low_bytes", {16'b0, cap_data[15:0]}, 32'h3CA5);
    chk("rd5_top_byte", {24'b0, cap_data[31:24]}, 32'd0);
    chk("rd5_ready", {31'b0, cmd_ready}, 32'd1);

    // reset during the 4th data bit of a write frame
    v0 = vld_cnt;
    issue(3'd2);
    tick(36);
    chk("mid_tx_bit3", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    chk("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick(2);
    issue(3'd1);
    check_frame(3'd1, 1'b0, "after_rst");
    chk("mid_rst_no_rsp", vld_cnt, v0);

    // read with no reply at all
    tick(1);
    issue(3'd3);
    check_frame(3'd3, 1'b1, "noreply");
`ifdef UART_DBG_TIMEOUT_EN
    tick(TOB * CPB - 1);
    chk("to_not_yet", {31'b0, rsp_valid}, 32'd0);
    tick(1);
    chk("to_pulse", {30'b0, rsp_valid, rsp_err}, 32'd3);
    tick(1);
    chk("to_ready", {31'b0, cmd_ready}, 32'd1);
`else
    v0 = vld_cnt;
    tick(200);
    chk("hang_busy", {31'b0, busy}, 32'd1);
    chk("hang_no_rsp", vld_cnt, v0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("hang_rst_ready", {31'b0, cmd_ready}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
